// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor. Each stage resolves one 4-bit lookahead group.
// Operands are skewed in, sum bits are deskewed out, and the whole pipe stalls on output backpressure.
module cla_adder_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    input  logic             sub_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             ovf_o
);
    localparam int G = WIDTH / 4;

    if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_width_check
        $error("cla_adder_pipe: WIDTH must be a multiple of 4 and at least 4");
    end

    // Returns {group carry-out, sum[3:0]}; every carry is a flat sum of products, with no ripple.
    function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic cin);
        logic [3:0] p;
        logic [3:0] g;
        logic [4:0] c;
        p    = a ^ b;
        g    = a & b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        return {c[4], p ^ c[3:0]};
    endfunction

    logic             advance_s;
    logic [WIDTH-1:0] b_eff_s;

    assign b_eff_s   = b_i ^ {WIDTH{sub_i}};
    assign advance_s = !valid_o || ready_i;
    assign ready_o   = advance_s;

    for (genvar k = 0; k < G; k++) begin : g_stage
        logic [3:0]     a_grp_s;
        logic [3:0]     b_grp_s;
        logic           cin_s;
        logic           valid_in_s;
        logic [4:0]     res_s;
        logic [4*k+3:0] sum_in_s;
        logic           valid_r;
        logic           cout_r;
        logic [4*k+3:0] sum_r;

        if (k == 0) begin : g_in
            assign a_grp_s    = a_i[3:0];
            assign b_grp_s    = b_eff_s[3:0];
            assign cin_s      = carry_i ^ sub_i;
            assign valid_in_s = valid_i;
            assign sum_in_s   = res_s[3:0];
        end else begin : g_in
            assign a_grp_s    = g_stage[k-1].g_skew.a_r[3:0];
            assign b_grp_s    = g_stage[k-1].g_skew.b_r[3:0];
            assign cin_s      = g_stage[k-1].cout_r;
            assign valid_in_s = g_stage[k-1].valid_r;
            assign sum_in_s   = {res_s[3:0], g_stage[k-1].sum_r};
        end

        assign res_s = cla4(a_grp_s, b_grp_s, cin_s);

        // Stage register: token valid, group carry-out and the completed (deskewed) sum bits.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_r <= 1'b0;
                cout_r  <= 1'b0;
                sum_r   <= '0;
            end else if (advance_s) begin
                valid_r <= valid_in_s;
                cout_r  <= res_s[4];
                sum_r   <= sum_in_s;
            end
        end

        // Operand bits still waiting for a later group ride along with their token.
        if (k < G - 1) begin : g_skew
            localparam int SW = WIDTH - 4 * (k + 1);
            logic [SW-1:0] a_next_s;
            logic [SW-1:0] b_next_s;
            logic [SW-1:0] a_r;
            logic [SW-1:0] b_r;

            if (k == 0) begin : g_src
                assign a_next_s = a_i[WIDTH-1:4];
                assign b_next_s = b_eff_s[WIDTH-1:4];
            end else begin : g_src
                assign a_next_s = g_stage[k-1].g_skew.a_r[SW+3:4];
                assign b_next_s = g_stage[k-1].g_skew.b_r[SW+3:4];
            end

            // Skew register for the not-yet-consumed operand bits.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    a_r <= '0;
                    b_r <= '0;
                end else if (advance_s) begin
                    a_r <= a_next_s;
                    b_r <= b_next_s;
                end
            end
        end

        if (k == G - 1) begin : g_last
            logic ovf_r;

            // Carry into the MSB is recovered as sum ^ a ^ b of that bit.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    ovf_r <= 1'b0;
                end else if (advance_s) begin
                    ovf_r <= res_s[4] ^ (res_s[3] ^ a_grp_s[3] ^ b_grp_s[3]);
                end
            end
        end
    end

    assign valid_o = g_stage[G-1].valid_r;
    assign sum_o   = g_stage[G-1].sum_r;
    assign carry_o = g_stage[G-1].cout_r;
    assign ovf_o   = g_stage[G-1].g_last.ovf_r;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Scoreboard bench for cla_adder_pipe (WIDTH=16): the driver pushes expected results on acceptance,
// and a monitor pops and compares on every output handshake.
module tb_cla_adder_pipe;
    localparam int W = 16;
    localparam int G = W / 4;

    logic         clk_i;
    logic         rst_ni;
    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         carry_i;
    logic         sub_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] sum_o;
    logic         carry_o;
    logic         ovf_o;

    cla_adder_pipe #(.WIDTH(W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
        .a_i(a_i), .b_i(b_i), .carry_i(carry_i), .sub_i(sub_i),
        .valid_o(valid_o), .ready_i(ready_i), .sum_o(sum_o),
        .carry_o(carry_o), .ovf_o(ovf_o)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         c;
        logic         o;
        int           acc_cyc;
        int           acc_stall;
    } exp_t;

    exp_t         exp_q[$];
    int           checks    = 0;
    int           errors    = 0;
    int           cyc       = 0;
    int           stall_cnt = 0;
    logic         held_v    = 1'b0;
    logic [W+1:0] held      = '0;
    logic         rnd_done  = 1'b0;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Independent reference: widened add, overflow from operand/result signs.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        logic [W-1:0] be;
        logic [W:0]   full;
        logic         ov;
        be   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, cin ^ sub};
        ov   = (a[W-1] == be[W-1]) && (full[W-1] != a[W-1]);
        return {ov, full[W], full[W-1:0]};
    endfunction

    // Presents one operation; pushes its expected {ovf, carry, sum} when it is accepted.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sub, input logic [W+1:0] expv);
        logic done;
        exp_t e;
        done    = 1'b0;
        a_i     = a;
        b_i     = b;
        carry_i = cin;
        sub_i   = sub;
        valid_i = 1'b1;
        for (int w = 0; w < 100 && !done; w++) begin
            @(negedge clk_i);
            if (ready_o && rst_ni) begin
                e.sum       = expv[W-1:0];
                e.c         = expv[W];
                e.o         = expv[W+1];
                e.acc_cyc   = cyc;
                e.acc_stall = stall_cnt;
                exp_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk_i);
            #1;
        end
        valid_i = 1'b0;
        if (!done) check("issue_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue_m(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                           input logic sub);
        issue(a, b, cin, sub, model(a, b, cin, sub));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check("drain_empty", exp_q.size(), 32'd0);
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: reset values, ready relation, stall stability and in-order result comparison.
    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_ni) begin
            check("rst_outputs", {valid_o, ready_o, carry_o, ovf_o}, {1'b0, 1'b1, 1'b0, 1'b0});
            check("rst_sum", sum_o, 32'd0);
            held_v = 1'b0;
        end else begin
            check("ready_rel", ready_o, !valid_o || ready_i);
            if (held_v) check("stall_stable", {valid_o, ovf_o, carry_o, sum_o}, {1'b1, held});
            if (valid_o && !ready_i) begin
                held_v = 1'b1;
                held   = {ovf_o, carry_o, sum_o};
                stall_cnt++;
            end else begin
                held_v = 1'b0;
            end
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sum", sum_o, e.sum);
                    check("carry", carry_o, e.c);
                    check("ovf", ovf_o, e.o);
                    if (e.acc_stall == stall_cnt) check("latency", cyc - e.acc_cyc, G);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni  = 1'b0;
        valid_i = 1'b1;
        a_i     = 16'h1234;
        b_i     = 16'h1111;
        carry_i = 1'b0;
        sub_i   = 1'b0;
        ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni  = 1'b1;
        valid_i = 1'b0;
        repeat (6) @(posedge clk_i);
        #1;

        // Directed vectors, one at a time.
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000}); drain();
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000}); drain();
        issue(16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE}); drain();
        issue(16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF}); drain();
        issue(16'h1234, 16'h4321, 1'b1, 1'b0, {1'b0, 1'b0, 16'h5556}); drain();
        issue(16'h0005, 16'h0003, 1'b1, 1'b1, {1'b0, 1'b1, 16'h0001}); drain();
        issue(16'h8000, 16'h8000, 1'b0, 1'b0, {1'b1, 1'b1, 16'h0000}); drain();
        issue(16'h0FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h1000}); drain();

        // Eight back-to-back ops with a three-cycle output stall mid-stream.
        fork
            begin
                for (int i = 0; i < 8; i++)
                    issue_m(16'(i * 16'h1111), 16'(16'h0F0F + i), 1'(i % 2), 1'((i / 2) % 2));
            end
            begin
                repeat (6) @(posedge clk_i);
                #1;
                ready_i = 1'b0;
                repeat (3) @(posedge clk_i);
                #1;
                ready_i = 1'b1;
            end
        join
        drain();

        // Three ops in flight, then a half-cycle reset pulse.
        issue_m(16'h1111, 16'h2222, 1'b0, 1'b0);
        issue_m(16'h3333, 16'h4444, 1'b0, 1'b0);
        issue_m(16'h5555, 16'h6666, 1'b0, 1'b1);
        @(posedge clk_i);
        #1;
        check("pre_rst_valid", valid_o, 1'b1);
        #1;
        rst_ni = 1'b0;
        #1;
        check("rst_async_valid", valid_o, 1'b0);
        check("rst_async_sum", sum_o, 32'd0);
        exp_q.delete();
        #4;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        repeat (6) @(posedge clk_i);
        #1;
        check("post_rst_idle", valid_o, 1'b0);
        issue(16'h00FF, 16'h0F01, 1'b0, 1'b0, {1'b0, 1'b0, 16'h1000});
        drain();

        // Random operands with random valid gaps and random output backpressure.
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 4) == 0) begin
                        @(posedge clk_i);
                        #1;
                    end
                    issue_m(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1)));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk_i);
                    #1;
                    ready_i = ($urandom_range(0, 3) != 0);
                end
                ready_i = 1'b1;
            end
        join
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
